fetch_seq: RTL and testbench
============================

# fetch_seq

Parametrised program-counter sequencer for the instruction fetch stage; it generalises the original 8-bit fetch counter. It adds a configurable PC width, absolute and relative branches, stall, halt, a run-state machine and an optional return-address stack (RAS) for call/return. Each cycle it drives the fetch address to instruction memory, together with a valid qualifier.

## Interface
Parameters:
- PC_W, 8, width of the program counter and all address ports
- RAS_DEPTH, 4, return-address stack entries (≥2, power of two)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start_i  in  1  load start_address_i and enter RUN
- start_address_i  in  PC_W  start address
- stall_i  in  1  hold the current PC
- halt_i  in  1  stop fetching and enter HALT
- branch_i  in  1  take a branch
- branch_abs_i  in  1  1: the target is absolute; 0: the target is a two's-complement offset from pc_o
- branch_target_i  in  PC_W  branch or call target, or offset
- call_i  in  1  push pc_o+1, then jump as for a branch
- ret_i  in  1  jump to the popped return address
- pc_o  out  PC_W  fetch address (registered)
- valid_o  out  1  pc_o is a live fetch address
- state_o  out  2  current state: IDLE=0, RUN=1, HALT=2
- ras_overflow_o  out  1  one-cycle pulse when a push overwrites the oldest entry
- ras_underflow_o  out  1  one-cycle pulse when a pop hits an empty stack

## Operation
- Reset values: pc_o=0, valid_o=0, state_o=IDLE, both RAS flags=0, RAS empty.
- States:
  - IDLE: pc_o and valid_o=0 are held. start_i → RUN.
  - RUN: valid_o=1. halt_i (without start_i) → HALT.
  - HALT: valid_o=0 and pc_o is held. start_i → RUN.
- start_i is honoured in every state, including during a stall:
  - loads start_address_i;
  - clears the RAS;
  - has highest priority.
- Next-PC priority in RUN with stall_i=0:
  1. start_i
  2. halt_i (pc_o holds)
  3. ret_i
  4. call_i
  5. branch_i
  6. pc_o+1
- stall_i=1 in RUN holds pc_o and ignores branch_i, call_i, ret_i and halt_i. The RAS is unchanged.
- Arithmetic:
  - All PC arithmetic is modulo 2^PC_W; pc_o+1 wraps from all-ones to 0.
  - A relative target is pc_o + branch_target_i, with the offset sign-interpreted and the sum truncated to PC_W.
- Call: pushes (pc_o+1) mod 2^PC_W and takes the target under the branch_abs_i rules. It does not need branch_i.
- Return: pops the top entry into pc_o.
  - If the stack is empty: pc_o+1 is taken instead and ras_underflow_o pulses.
- ret_i together with call_i: ret wins and the call is ignored, with no push.
- Push to a full RAS: the oldest entry is overwritten (circular), the depth stays RAS_DEPTH, and ras_overflow_o pulses.
- Reset mid-operation overrides every input and returns all state to the reset values above.

## Timing
- Latency is one cycle. Inputs sampled at edge N determine pc_o and valid_o after edge N.
- A redirect (start, branch, call, ret) shows up on pc_o in the cycle after it is asserted. No bubble is inserted.
- valid_o rises with the first start address and falls the cycle after halt_i is sampled.
- The RAS flags are registered. They are high for exactly the one cycle after the offending push or pop.
- There are no combinational paths from inputs to outputs.

## Configuration
- FETCH_RAS_EN defined: the RAS is instantiated with the behaviour above.
- FETCH_RAS_EN undefined:
  - call_i behaves exactly like branch_i, with no push;
  - ret_i is ignored and the PC advances normally;
  - ras_overflow_o and ras_underflow_o are tied to 0;
  - no RAS storage is built.

## Structure
- Package fetch_pkg holds:
  - the fetch_state_e enum (IDLE, RUN, HALT; 2 bits);
  - default PC_W and RAS_DEPTH constants;
  - a next-PC source enum used for debug.
- Sub-module fetch_ras is a parametrised circular stack with:
  - inputs clk, rst, clear, push, pop and push data;
  - outputs top, empty, full and the overflow/underflow pulses;
  - instantiation only under FETCH_RAS_EN.
- fetch_seq holds the FSM, the next-PC mux and the PC register.

## Test plan
- Reset, then start_i with start_address_i=0x10 → pc_o 0x10, 0x11, 0x12, valid_o=1, state_o=RUN.
- At pc_o=0x20: relative branch with offset 0xFC → pc_o=0x1C. Then an absolute branch to 0x80 → pc_o=0x80. Then stall_i for 3 cycles with branch_i=1 → pc_o holds 0x80 and the branch is ignored.
- PC_W=8 at pc_o=0xFF with no redirect → pc_o=0x00 next cycle.
- FETCH_RAS_EN, RAS_DEPTH=4:
  - five calls from 0x01, 0x11, 0x21, 0x31, 0x41 → ras_overflow_o pulses on the fifth call;
  - five returns → pc_o=0x42, 0x32, 0x22, 0x12;
  - the fifth return gives ras_underflow_o and pc+1.
- halt_i at pc_o=0x05 → valid_o=0, pc_o holds 0x05, state_o=HALT. Then start_i to 0x40 → RUN with pc_o=0x40.
- rst asserted mid-RUN with call_i=1 → next cycle pc_o=0, valid_o=0, IDLE. A following ret_i after start gives an underflow (RAS empty).

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction-fetch PC sequencer.
//   fetch_state_e : run state reported on state_o (IDLE=0, RUN=1, HALT=2)
//   fetch_src_e   : which source feeds the next PC (debug visibility)
//   FETCH_PC_W, FETCH_RAS_DEPTH : default parameter values
package fetch_pkg;

  localparam int FETCH_PC_W      = 8;
  localparam int FETCH_RAS_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef enum logic [2:0] {
    SRC_HOLD   = 3'd0,
    SRC_START  = 3'd1,
    SRC_RET    = 3'd2,
    SRC_CALL   = 3'd3,
    SRC_BRANCH = 3'd4,
    SRC_INC    = 3'd5
  } fetch_src_e;

endpackage

// File: rtl/fetch_ras.sv
// fetch_ras: circular return-address stack.
//   clk, rst       : clock, synchronous active-high reset
//   clear          : empty the stack (start of a new program)
//   push/push_data : push an address; on a full stack the oldest entry is overwritten
//   pop            : discard the top entry; popping an empty stack only flags underflow
//   top            : current top entry (valid when !empty)
//   empty, full    : occupancy status
//   overflow/underflow : registered one-cycle pulses after the offending push/pop
module fetch_ras
  import fetch_pkg::*;
#(
  parameter int PC_W      = FETCH_PC_W,
  parameter int RAS_DEPTH = FETCH_RAS_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            empty,
  output logic            full,
  output logic            overflow,
  output logic            underflow
);

  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);

  logic [PC_W-1:0] mem [RAS_DEPTH];
  // ptr_p0 is the next free slot; with a full stack it also points at the oldest entry
  logic [AW-1:0]   ptr_p0;
  logic [CW-1:0]   cnt_p0;

  assign empty = (cnt_p0 == '0);
  assign full  = (cnt_p0 == CNT_FULL);
  assign top   = mem[ptr_p0 - PTR_ONE];

  // ---- stage p0: stack pointer, occupancy and flags ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_p0    <= '0;
      cnt_p0    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= push && full && !clear;
      underflow <= pop && !push && empty && !clear;
      if (clear) begin
        ptr_p0 <= '0;
        cnt_p0 <= '0;
      end else if (push) begin
        ptr_p0 <= ptr_p0 + PTR_ONE;
        if (!full) cnt_p0 <= cnt_p0 + CNT_ONE;
      end else if (pop && !empty) begin
        ptr_p0 <= ptr_p0 - PTR_ONE;
        cnt_p0 <= cnt_p0 - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[ptr_p0] <= push_data;
  end

endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: program-counter sequencer for the instruction fetch stage.
// Optional feature macro: FETCH_RAS_EN (builds the return-address stack for
// call/return; without it call_i acts as branch_i and ret_i is ignored).
//   clk, rst            : clock, synchronous active-high reset
//   start_i/start_address_i : load a start address and enter RUN (highest priority)
//   stall_i             : hold the PC while running
//   halt_i              : stop fetching, enter HALT
//   branch_i/branch_abs_i/branch_target_i : absolute or PC-relative redirect
//   call_i, ret_i       : call (push pc+1) and return (pop)
//   pc_o, valid_o       : registered fetch address and its qualifier
//   state_o             : IDLE=0, RUN=1, HALT=2
//   ras_overflow_o/ras_underflow_o : one-cycle RAS error pulses
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int PC_W      = FETCH_PC_W,
  parameter int RAS_DEPTH = FETCH_RAS_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [PC_W-1:0] start_address_i,
  input  logic            stall_i,
  input  logic            halt_i,
  input  logic            branch_i,
  input  logic            branch_abs_i,
  input  logic [PC_W-1:0] branch_target_i,
  input  logic            call_i,
  input  logic            ret_i,
  output logic [PC_W-1:0] pc_o,
  output logic            valid_o,
  output logic [1:0]      state_o,
  output logic            ras_overflow_o,
  output logic            ras_underflow_o
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  // Offset is two's complement; the sum wraps modulo 2^PC_W.
  function automatic logic [PC_W-1:0] pc_rel(input logic [PC_W-1:0]        base,
                                             input logic signed [PC_W-1:0] off);
    logic signed [PC_W:0] sum;
    sum = $signed({1'b0, base}) + $signed({off[PC_W-1], off});
    return sum[PC_W-1:0];
  endfunction

  fetch_state_e    state_p0, state_nxt;
  logic [PC_W-1:0] pc_p0, pc_nxt;
  logic [PC_W-1:0] br_tgt;
  fetch_src_e      src;

`ifdef FETCH_RAS_EN
  logic            ras_push, ras_pop, ras_empty;
  logic            ras_full_unused;
  logic [PC_W-1:0] ras_top;
`else
  logic            unused_ret;
  assign unused_ret = ret_i;
`endif

  always_comb begin
    state_nxt = state_p0;
    src       = SRC_HOLD;
`ifdef FETCH_RAS_EN
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
`endif
    if (start_i) begin
      state_nxt = RUN;
      src       = SRC_START;
    end else if (state_p0 == RUN && !stall_i) begin
      if (halt_i) begin
        state_nxt = HALT;
`ifdef FETCH_RAS_EN
      end else if (ret_i) begin
        // an empty stack falls back to sequential fetch
        ras_pop = 1'b1;
        src     = ras_empty ? SRC_INC : SRC_RET;
      end else if (call_i) begin
        ras_push = 1'b1;
        src      = SRC_CALL;
`else
      end else if (call_i) begin
        src = SRC_BRANCH;
`endif
      end else if (branch_i) begin
        src = SRC_BRANCH;
      end else begin
        src = SRC_INC;
      end
    end
  end

  assign br_tgt = branch_abs_i ? branch_target_i : pc_rel(pc_p0, branch_target_i);

  always_comb begin
    pc_nxt = pc_p0;
    case (src)
      SRC_START:           pc_nxt = start_address_i;
`ifdef FETCH_RAS_EN
      SRC_RET:             pc_nxt = ras_top;
`endif
      SRC_CALL, SRC_BRANCH: pc_nxt = br_tgt;
      SRC_INC:             pc_nxt = pc_p0 + PC_ONE;
      default:             pc_nxt = pc_p0;
    endcase
  end

  // ---- stage p0: run state and PC register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= IDLE;
      pc_p0    <= '0;
    end else begin
      state_p0 <= state_nxt;
      pc_p0    <= pc_nxt;
    end
  end

  assign pc_o    = pc_p0;
  assign valid_o = (state_p0 == RUN);
  assign state_o = state_p0;

`ifdef FETCH_RAS_EN
  fetch_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_i),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_p0 + PC_ONE),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full_unused),
    .overflow  (ras_overflow_o),
    .underflow (ras_underflow_o)
  );
`else
  assign ras_overflow_o  = 1'b0;
  assign ras_underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed scenarios plus randomized stimulus for fetch_seq,
// checked cycle by cycle against a behavioural model (integer PC, queue RAS).
module tb_fetch_seq;

  localparam int PC_W      = 8;
  localparam int RAS_DEPTH = 4;
  localparam int MASK      = (1 << PC_W) - 1;
`ifdef FETCH_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            start_i;
  logic [PC_W-1:0] start_address_i;
  logic            stall_i;
  logic            halt_i;
  logic            branch_i;
  logic            branch_abs_i;
  logic [PC_W-1:0] branch_target_i;
  logic            call_i;
  logic            ret_i;
  logic [PC_W-1:0] pc_o;
  logic            valid_o;
  logic [1:0]      state_o;
  logic            ras_overflow_o;
  logic            ras_underflow_o;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_pc, m_state, m_ov, m_un;
  int m_ras[$];

  fetch_seq #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start_i),
    .start_address_i (start_address_i),
    .stall_i         (stall_i),
    .halt_i          (halt_i),
    .branch_i        (branch_i),
    .branch_abs_i    (branch_abs_i),
    .branch_target_i (branch_target_i),
    .call_i          (call_i),
    .ret_i           (ret_i),
    .pc_o            (pc_o),
    .valid_o         (valid_o),
    .state_o         (state_o),
    .ras_overflow_o  (ras_overflow_o),
    .ras_underflow_o (ras_underflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr_in();
    rst = 1'b0; start_i = 1'b0; start_address_i = '0; stall_i = 1'b0; halt_i = 1'b0;
    branch_i = 1'b0; branch_abs_i = 1'b0; branch_target_i = '0; call_i = 1'b0; ret_i = 1'b0;
  endtask

  function automatic int to_off(input int t);
    return (t >= (1 << (PC_W - 1))) ? t - (1 << PC_W) : t;
  endfunction

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    int inc, tgt;
    inc  = (m_pc + 1) & MASK;
    tgt  = branch_abs_i ? int'(branch_target_i)
                        : ((m_pc + to_off(int'(branch_target_i))) & MASK);
    m_ov = 0;
    m_un = 0;
    if (rst) begin
      m_pc = 0; m_state = 0; m_ras.delete();
    end else if (start_i) begin
      m_pc = int'(start_address_i); m_state = 1; m_ras.delete();
    end else if (m_state == 1 && !stall_i) begin
      if (halt_i) begin
        m_state = 2;
      end else if (RAS_EN && ret_i) begin
        if (m_ras.size() == 0) begin
          m_un = 1; m_pc = inc;
        end else begin
          m_pc = m_ras.pop_back();
        end
      end else if (call_i || branch_i) begin
        if (RAS_EN && call_i) begin
          if (m_ras.size() == RAS_DEPTH) begin
            void'(m_ras.pop_front());
            m_ov = 1;
          end
          m_ras.push_back(inc);
        end
        m_pc = tgt;
      end else begin
        m_pc = inc;
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("pc", 32'(pc_o), m_pc);
    chk("valid", 32'(valid_o), (m_state == 1) ? 1 : 0);
    chk("state", 32'(state_o), m_state);
    chk("ovf", 32'(ras_overflow_o), m_ov);
    chk("unf", 32'(ras_underflow_o), m_un);
  endtask

  task automatic go_start(input int a);
    clr_in(); start_i = 1'b1; start_address_i = PC_W'(a); cyc(); clr_in();
  endtask

  task automatic go_idle(input int n);
    clr_in();
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic go_br(input bit abs, input int t);
    clr_in(); branch_i = 1'b1; branch_abs_i = abs; branch_target_i = PC_W'(t); cyc(); clr_in();
  endtask

  task automatic go_call(input int t);
    clr_in(); call_i = 1'b1; branch_abs_i = 1'b1; branch_target_i = PC_W'(t); cyc(); clr_in();
  endtask

  task automatic go_ret();
    clr_in(); ret_i = 1'b1; cyc(); clr_in();
  endtask

  initial begin
    clr_in();
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_pc", 32'(pc_o), 0);
    chk("rst_state", 32'(state_o), 0);
    clr_in();
    go_idle(2);
    chk("idle_valid", 32'(valid_o), 0);

    // start and sequential fetch
    go_start('h10);
    chk("start_pc", 32'(pc_o), 'h10);
    go_idle(1);
    chk("seq_pc1", 32'(pc_o), 'h11);
    go_idle(1);
    chk("seq_pc2", 32'(pc_o), 'h12);
    chk("run_valid", 32'(valid_o), 1);
    chk("run_state", 32'(state_o), 1);

    // relative and absolute branches, stall ignoring a branch
    go_start('h20);
    go_br(1'b0, 'hFC);
    chk("rel_br", 32'(pc_o), 'h1C);
    go_br(1'b1, 'h80);
    chk("abs_br", 32'(pc_o), 'h80);
    for (int i = 0; i < 3; i++) begin
      clr_in(); stall_i = 1'b1; branch_i = 1'b1; branch_abs_i = 1'b1; branch_target_i = 8'h33;
      cyc();
      chk("stall_hold", 32'(pc_o), 'h80);
    end
    clr_in();

    // wrap-around
    go_start('hFF);
    go_idle(1);
    chk("wrap", 32'(pc_o), 'h00);

    // call/return chain, overflow on the fifth push, underflow on the fifth pop
    go_start('h01);
    go_call('h11);
    go_call('h21);
    go_call('h31);
    go_call('h41);
    go_call('h50);
`ifdef FETCH_RAS_EN
    chk("ovf_pulse", 32'(ras_overflow_o), 1);
`endif
    go_idle(1);
`ifdef FETCH_RAS_EN
    chk("ovf_clear", 32'(ras_overflow_o), 0);
`endif
    go_ret();
`ifdef FETCH_RAS_EN
    chk("ret1", 32'(pc_o), 'h42);
`endif
    go_ret();
`ifdef FETCH_RAS_EN
    chk("ret2", 32'(pc_o), 'h32);
`endif
    go_ret();
    go_ret();
`ifdef FETCH_RAS_EN
    chk("ret4", 32'(pc_o), 'h12);
`endif
    go_ret();
`ifdef FETCH_RAS_EN
    chk("unf_pulse", 32'(ras_underflow_o), 1);
    chk("unf_pc", 32'(pc_o), 'h13);
`endif

    // halt and restart
    go_start('h05);
    clr_in(); halt_i = 1'b1; cyc(); clr_in();
    chk("halt_valid", 32'(valid_o), 0);
    chk("halt_pc", 32'(pc_o), 'h05);
    chk("halt_state", 32'(state_o), 2);
    go_idle(2);
    go_start('h40);
    chk("restart_pc", 32'(pc_o), 'h40);
    chk("restart_state", 32'(state_o), 1);

    // reset during a call, then a return on the cleared stack
    go_call('h70);
    clr_in(); rst = 1'b1; call_i = 1'b1; branch_abs_i = 1'b1; branch_target_i = 8'h90;
    cyc();
    chk("midrst_pc", 32'(pc_o), 0);
    chk("midrst_state", 32'(state_o), 0);
    clr_in();
    go_start('h08);
    go_ret();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst             = ($urandom_range(99) == 0);
      start_i         = ($urandom_range(19) == 0);
      start_address_i = PC_W'($urandom_range(MASK));
      stall_i         = ($urandom_range(4) == 0);
      halt_i          = ($urandom_range(24) == 0);
      branch_i        = ($urandom_range(3) == 0);
      branch_abs_i    = $urandom_range(1) == 1;
      branch_target_i = PC_W'($urandom_range(MASK));
      call_i          = ($urandom_range(4) == 0);
      ret_i           = ($urandom_range(4) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
